tick_gen_prog: RTL and testbench
================================

Name: tick_gen_prog

Overview:
- Programmable enable-pulse (tick) generator; the next generation of the fixed 1 Hz enable divider.
- Divides clk by a runtime-loadable divisor. Supports run/pause, synchronous clear, periodic or one-shot mode, and a 50%-duty blink output.
- Feeds watch timekeeping, display-blink and debounce logic that need single-cycle enables at configurable rates.

Parameters:
- CNT_W, 26: width of the counter, divisor input and count output.
- DIV_RST, 50000000: divisor loaded at reset (1 Hz at 50 MHz). Must satisfy 1 <= DIV_RST <= 2^CNT_W - 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 = count, 0 = pause (count held).
- clr  in  1  synchronous clear strobe.
- load  in  1  divisor load strobe.
- div_in  in  CNT_W  new divisor, sampled when load=1.
- oneshot  in  1  mode; 1 = stop after the next tick, 0 = periodic. Sampled at terminal count.
- tick  out  1  registered enable pulse, exactly one clk wide.
- blink  out  1  registered square wave; toggles on every tick.
- cnt  out  CNT_W  current count value.
- busy  out  1  1 when state = RUN.
- load_err  out  1  sticky; set by a load with div_in = 0.

Behaviour:
- Reset (rst=0, async):
  - cnt=0, div_reg=DIV_RST, state=IDLE.
  - tick=0, blink=0, busy=0, load_err=0.
- States:
  - IDLE -> RUN when run=1. cnt is unchanged on this transition.
  - RUN -> IDLE when run=0. cnt is held (pause, not clear).
  - RUN -> DONE at terminal count when oneshot=1.
  - DONE -> IDLE on clr or a valid load. run is ignored in DONE.
- Counting (RUN only):
  - Each cycle, cnt <= cnt+1.
  - Terminal count is cnt == div_reg-1. At terminal: cnt <= 0, tick <= 1, blink <= ~blink.
  - tick is 0 in every other cycle and in every state other than RUN.
- Timing:
  - Tick period is exactly div_reg cycles.
  - First tick is high in the cycle after edge number div_reg+1, counting the edge that sampled run=1 as edge 1.
  - With div_reg=1, tick is high every cycle from the second RUN cycle onward, and blink toggles every cycle.
- Priority per cycle: clr > load > counting.
- clr:
  - cnt <= 0, tick <= 0, blink <= 0, load_err <= 0.
  - state <= IDLE. A following cycle with run=1 re-enters RUN.
  - div_reg is unchanged.
- Valid load (div_in >= 1):
  - div_reg <= div_in, cnt <= 0, tick <= 0. blink is unchanged.
  - In RUN, the new period restarts from 0 on the next edge. In DONE, state <= IDLE. In IDLE, state stays IDLE.
- Invalid load (div_in = 0):
  - div_reg, cnt and state are unchanged.
  - load_err <= 1 and stays set until clr or reset.
- One-shot: at terminal count with oneshot=1, the tick is emitted and state <= DONE. busy drops in the same cycle tick is high.
- Pause at terminal: if run falls on the cycle cnt == div_reg-1, no tick is emitted and cnt holds at div_reg-1. The tick fires on the first RUN cycle after resume.
- Divisor reduced below cnt: impossible, because every load zeroes cnt.
- Counter width: cnt never exceeds div_reg-1, so no overflow or wrap handling beyond the terminal compare is needed.
- Outputs are all registered; no combinational path from any input to any output.

Test Plan:
- Reset, then load div_in=4, then run=1 held -> tick high for exactly 1 cycle every 4 cycles; first tick 5 edges after run sampled. blink sequence 1,0,1,... per tick. cnt cycles 0,1,2,3.
- div=5, run=1, drop run at cnt=2 for 10 cycles, then restore -> cnt holds 2, no tick while paused. Next tick after 3 more RUN edges (cnt 3, 4, then terminal).
- div=3, oneshot=1, run=1 -> exactly one tick, busy falls with it, cnt=0, no further ticks for 20 cycles. clr, then run again -> one more tick.
- Load div_in=0 while running with div=6 -> load_err=1, period stays 6. clr -> load_err=0, cnt=0, blink=0.
- load and clr asserted in the same cycle with div_in=7 -> clr wins: div_reg unchanged, cnt=0. Load again with div_in=7 -> period becomes 7, restarting from cnt=0.
- Default divisor: reset, run=1 with DIV_RST overridden to 10 -> first tick after 11 edges, then every 10. Assert rst mid-count -> all outputs zero immediately (async), div_reg back to 10.

Source files
------------

// File: rtl/tick_gen_prog.sv
// -----------------------------------------------------------------------------
// tick_gen_prog
//
// Programmable enable-pulse generator. Divides clk by a divisor that can be
// reloaded at run time. It emits a single-cycle `tick` once every `div_reg`
// cycles while running. A 50%-duty-per-tick `blink` square wave is produced
// alongside the ticks. It can run periodically or stop after one tick.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-low reset
//   run       in   level: 1 = count, 0 = pause (count is held, not cleared)
//   clr       in   synchronous clear strobe (highest priority)
//   load      in   divisor load strobe (div_in sampled when high)
//   div_in    in   [CNT_W] new divisor; 0 is rejected and flags load_err
//   oneshot   in   1 = enter DONE after the next tick, 0 = periodic
//   tick      out  registered enable pulse, one clk wide
//   blink     out  registered square wave, toggles on every tick
//   cnt       out  [CNT_W] current count value
//   busy      out  1 while the generator is in RUN
//   load_err  out  sticky flag set by a load with div_in = 0
//
// Every output comes straight from a flop. No combinational path runs from
// any input to any output.
// -----------------------------------------------------------------------------
module tick_gen_prog #(
  parameter int          CNT_W   = 26,
  parameter int unsigned DIV_RST = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             oneshot,
  output logic             tick,
  output logic             blink,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             blink_q, blink_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             at_terminal;
  logic             div_in_valid;

  // The counter never exceeds div_q-1. A load always zeroes it, so the
  // terminal compare alone is enough and no wrap handling is required.
  assign at_terminal  = (cnt_q == (div_q - CNT_ONE));
  assign div_in_valid = (div_in != CNT_ZERO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    blink_d = blink_q;
    err_d   = err_q;

    if (clr) begin
      // Clear returns everything to a known idle point. The divisor is kept.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      blink_d = 1'b0;
      err_d   = 1'b0;
    end else if (load) begin
      if (div_in_valid) begin
        // A new period always starts from zero. In RUN it restarts on the
        // next edge. A load also re-arms a finished one-shot.
        div_d = div_in;
        cnt_d = CNT_ZERO;
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end else begin
        // A zero divisor is rejected. This cycle is consumed with
        // the count, the divisor and the state all frozen.
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Entering RUN does not advance the count. The first
          // increment happens on the following edge.
          if (run) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!run) begin
            // Pause, even at terminal count. The tick is deferred
            // until counting resumes.
            state_d = ST_IDLE;
          end else if (at_terminal) begin
            cnt_d   = CNT_ZERO;
            tick_d  = 1'b1;
            blink_d = ~blink_q;
            if (oneshot) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          // run is deliberately ignored here. Only clr or a valid load leave.
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // busy is registered from the next state. It therefore falls in the
    // same cycle as the one-shot tick.
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      div_q   <= DIV_RST_V;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign tick     = tick_q;
  assign blink    = blink_q;
  assign cnt      = cnt_q;
  assign busy     = busy_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_tick_gen_prog.sv
// -----------------------------------------------------------------------------
// tb_tick_gen_prog
//
// Self-checking bench for tick_gen_prog. The design runs with an 8-bit
// counter and a reset divisor of 10. A behavioural model counts edges in
// plain integers and is updated at every rising edge. All outputs are
// compared against the model 1 ns after that edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_gen_prog;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 10;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic             oneshot = 1'b0;
  logic             tick;
  logic             blink;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             load_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_mode;
  int m_cnt;
  int m_div;
  int m_tick;
  int m_blink;
  int m_err;

  tick_gen_prog #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .load     (load),
    .div_in   (div_in),
    .oneshot  (oneshot),
    .tick     (tick),
    .blink    (blink),
    .cnt      (cnt),
    .busy     (busy),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_div   = DIV_RST;
    m_tick  = 0;
    m_blink = 0;
    m_err   = 0;
  endtask

  // The model counts edges since the period started. A tick is due when
  // the running edge count reaches the divisor.
  task automatic model_step();
    m_tick = 0;
    if (clr) begin
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_blink = 0;
      m_err   = 0;
    end else if (load) begin
      if (int'(div_in) == 0) begin
        m_err = 1;
      end else begin
        m_div = int'(div_in);
        m_cnt = 0;
        if (m_mode == M_DONE) m_mode = M_IDLE;
      end
    end else if (m_mode == M_RUN) begin
      if (!run) begin
        m_mode = M_IDLE;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_div) begin
          m_cnt   = 0;
          m_tick  = 1;
          m_blink = 1 - m_blink;
          if (oneshot) m_mode = M_DONE;
        end
      end
    end else if (m_mode == M_IDLE && run) begin
      m_mode = M_RUN;
    end
  endtask

  task automatic check_all();
    chk("tick", int'(tick), m_tick);
    chk("blink", int'(blink), m_blink);
    chk("cnt", int'(cnt), m_cnt);
    chk("busy", int'(busy), (m_mode == M_RUN) ? 1 : 0);
    chk("load_err", int'(load_err), m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_inputs();
    run = 1'b0; clr = 1'b0; load = 1'b0; div_in = '0; oneshot = 1'b0;
  endtask

  // Assert reset between edges. The outputs must clear at once, with no
  // clock edge involved.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_tick", int'(tick), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(load_err), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic load_div(input int d);
    load = 1'b1; div_in = CNT_W'(d);
    cycle();
    load = 1'b0; div_in = '0;
  endtask

  // With the reset divisor, the first tick comes after DIV_RST+1 edges,
  // counting the edge that samples run=1.
  task automatic first_tick_after_reset();
    int k;
    int seen;
    seen = 0;
    run = 1'b1;
    for (k = 1; k <= 40; k++) begin
      cycle();
      if (tick) begin
        seen = k;
        break;
      end
    end
    chk("first_tick_edge", seen, DIV_RST + 1);
    seen = 0;
    for (k = 1; k <= 40; k++) begin
      cycle();
      if (tick) begin
        seen = k;
        break;
      end
    end
    chk("default_period", seen, DIV_RST);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    rst = 1'b1;
    #1;
    check_all();

    // Default divisor, then an asynchronous reset in the middle of a count.
    first_tick_after_reset();
    cycles(4);
    apply_reset();
    run = 1'b0;
    cycle();
    first_tick_after_reset();
    run = 1'b0;
    cycle();

    // div=4 periodic run
    load_div(4);
    run = 1'b1;
    cycles(20);

    // div=5, pause at cnt=2 for 10 cycles, then resume
    run = 1'b0;
    cycle();
    load_div(5);
    run = 1'b1;
    for (int i = 0; i < 20 && m_cnt != 2; i++) cycle();
    chk("pause_cnt_reached", m_cnt, 2);
    run = 1'b0;
    cycles(10);
    run = 1'b1;
    cycles(12);

    // div=3 one-shot, clr, then another one-shot
    run = 1'b0;
    cycle();
    load_div(3);
    oneshot = 1'b1;
    run = 1'b1;
    cycles(25);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycles(10);
    oneshot = 1'b0;

    // Invalid load while running with div=6
    run = 1'b0;
    cycle();
    load_div(6);
    run = 1'b1;
    cycles(8);
    load_div(0);
    chk("err_set", int'(load_err), 1);
    cycles(14);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("err_cleared", int'(load_err), 0);

    // load and clr together: clr wins, then a real load of 7
    run = 1'b1;
    cycles(3);
    clr = 1'b1; load = 1'b1; div_in = CNT_W'(7);
    cycle();
    clr = 1'b0; load = 1'b0; div_in = '0;
    cycles(12);
    load_div(7);
    cycles(16);

    // Randomized traffic with small divisors
    for (int i = 0; i < 3000; i++) begin
      run     = ($urandom_range(0, 99) < 85);
      clr     = ($urandom_range(0, 99) < 2);
      load    = ($urandom_range(0, 99) < 4);
      div_in  = CNT_W'($urandom_range(0, 6));
      oneshot = ($urandom_range(0, 99) < 15);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
